// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives a synchronous-read instruction memory, applies stalls and branch squashes.
module if_stage #(
    parameter int unsigned    PC_W     = 8,
    parameter int unsigned    INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid_out,
    output logic               flush_id_ex,
    output logic [15:0]        fetch_count
);

    localparam int unsigned CNT_W = 16;

    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_next_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_out;
    logic               r_valid;
    logic [CNT_W-1:0]   r_fetch_count;

    // Next-PC mux: reset > branch > stall > sequential
    always_comb begin
        w_next_pc = r_pc + PC_W'(1);
        if (reset) begin
            w_next_pc = RESET_PC;
        end else if (branch_taken) begin
            w_next_pc = branch_target;
        end else if (stall) begin
            w_next_pc = r_pc;
        end
    end

    // PC follows next-PC every edge, so imem_rdata always holds the word at r_pc
    always_ff @(posedge clk) begin
        r_pc <= w_next_pc;
    end

    // IF/ID register and accepted-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr       <= '0;
            r_pc_out      <= '0;
            r_valid       <= 1'b0;
            r_fetch_count <= '0;
        end else if (branch_taken) begin
            r_instr  <= '0;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
        end else if (!stall) begin
            r_instr       <= imem_rdata;
            r_pc_out      <= r_pc;
            r_valid       <= 1'b1;
            r_fetch_count <= r_fetch_count + CNT_W'(1);
        end
    end

    assign imem_addr   = w_next_pc;
    assign flush_id_ex = branch_taken;
    assign instr_out   = r_instr;
    assign pc_out      = r_pc_out;
    assign valid_out   = r_valid;
    assign fetch_count = r_fetch_count;

endmodule
